// File: rtl/abb_pkg.sv
// Shared definitions for the A-B-B burst scheduler.
// Holds symbol encodings, scheduler FSM states and detector progress states.
package abb_pkg;

    localparam logic [1:0] SYM_A   = 2'b00;
    localparam logic [1:0] SYM_B   = 2'b01;
    localparam logic [1:0] SYM_C   = 2'b11;
    localparam logic [1:0] SYM_INV = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DET_NONE = 2'd0,
        DET_A    = 2'd1,
        DET_AB   = 2'd2
    } det_t;

endpackage

// File: rtl/abb_det.sv
// A-B-B sequence detector with registered match output.
// Ports: clock, reset, clear (progress flush), valid/sym (symbol in), match (out).
module abb_det
    import abb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       valid,
    input  logic [1:0] sym,
    output logic       match
);

    det_t prog;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            prog  <= DET_NONE;
            match <= 1'b0;
        end else begin
            match <= 1'b0;
            if (valid) begin
                unique case (sym)
                    SYM_A: prog <= DET_A;
                    SYM_B: begin
                        if (prog == DET_A) begin
                            prog <= DET_AB;
                        end else if (prog == DET_AB) begin
                            // completed A,B,B; progress restarts from nothing
                            prog  <= DET_NONE;
                            match <= 1'b1;
                        end else begin
                            prog <= DET_NONE;
                        end
                    end
                    default: prog <= DET_NONE;
                endcase
            end
        end
    end

endmodule

// File: rtl/abb_sched.sv
// Two-source burst scheduler: round-robin grant, A-B-B match counting per burst.
// Ports: clock/reset, req/sym/last per source, gnt per source, done + result fields.
module abb_sched
    import abb_pkg::*;
#(
    parameter int HIT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [1:0]       sym0,
    input  logic [1:0]       sym1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic             done_src,
    output logic [HIT_W-1:0] done_hits,
    output logic             done_err
);

    localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

    state_t           state;
    logic             rr;
    logic             owner;
    logic [HIT_W-1:0] hits;
    logic             err;

    logic             cons;
    logic [1:0]       cur_sym;
    logic             cur_last;
    logic             pick;
    logic             start;
    logic             match;
    logic [HIT_W-1:0] hits_nx;

    always_comb begin
        cur_sym  = owner ? sym1 : sym0;
        cur_last = owner ? last1 : last0;
        cons     = (state == ST_RUN) &&
                   (owner ? (req1 && gnt1) : (req0 && gnt0));
        start    = (state == ST_IDLE) && (req0 || req1);
        pick     = rr;
        if (req0 && !req1) begin
            pick = 1'b0;
        end else if (req1 && !req0) begin
            pick = 1'b1;
        end
        hits_nx = hits;
        if (match && (hits != HIT_MAX)) begin
            hits_nx = hits + HIT_W'(1);
        end
    end

    abb_det u_det (
        .clock (clock),
        .reset (reset),
        .clear (start),
        .valid (cons),
        .sym   (cur_sym),
        .match (match)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr        <= 1'b0;
            owner     <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            hits      <= '0;
            err       <= 1'b0;
            done      <= 1'b0;
            done_src  <= 1'b0;
            done_hits <= '0;
            done_err  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        owner <= pick;
                        gnt0  <= ~pick;
                        gnt1  <= pick;
                        hits  <= '0;
                        err   <= 1'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    hits <= hits_nx;
                    if (cons && (cur_sym == SYM_INV)) begin
                        err <= 1'b1;
                    end
                    if (cons && cur_last) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // a match from the final symbol lands here; fold it in
                    hits      <= hits_nx;
                    rr        <= ~owner;
                    done      <= 1'b1;
                    done_src  <= owner;
                    done_hits <= hits_nx;
                    done_err  <= err;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_abb_sched.sv
// Scoreboard bench for abb_sched: directed bursts, expected results queued.
// Monitor compares every done pulse against the queue head.
module tb_abb_sched;
    import abb_pkg::*;

    typedef struct packed {
        logic       src;
        logic [3:0] hits;
        logic       err;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       req0, req1;
    logic [1:0] sym0, sym1;
    logic       last0, last1;
    logic       gnt0, gnt1;
    logic       done, done_src, done_err;
    logic [3:0] done_hits;

    int   checks = 0;
    int   errors = 0;
    int   gcnt0  = 0;
    int   gcnt1  = 0;
    exp_t expq[$];

    abb_sched #(.HIT_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .sym0      (sym0),
        .sym1      (sym1),
        .last0     (last0),
        .last1     (last1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done      (done),
        .done_src  (done_src),
        .done_hits (done_hits),
        .done_err  (done_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (gnt0) gcnt0++;
        if (gnt1) gcnt1++;
        if (!reset && done) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done src=%0d hits=%0d err=%0d",
                         done_src, done_hits, done_err);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("done_src", int'(done_src), int'(e.src));
                chk("done_hits", int'(done_hits), int'(e.hits));
                chk("done_err", int'(done_err), int'(e.err));
            end
        end
    end

    task automatic drive(input bit src, input logic r,
                         input logic [1:0] s, input logic l);
        if (src) begin
            req1 = r; sym1 = s; last1 = l;
        end else begin
            req0 = r; sym0 = s; last0 = l;
        end
    endtask

    task automatic send(input bit src, input logic [1:0] s[$],
                        input int gap, input bit uselast);
        for (int i = 0; i < s.size(); i++) begin
            int n;
            if (i > 0) begin
                repeat (gap) begin
                    drive(src, 1'b0, SYM_C, 1'b0);
                    @(negedge clock);
                end
            end
            drive(src, 1'b1, s[i], uselast && (i == s.size() - 1));
            n = 0;
            while (!(src ? gnt1 : gnt0)) begin
                @(negedge clock);
                n++;
                if (n > 300) begin
                    checks++;
                    errors++;
                    $display("FAIL grant_timeout src=%0d actual=0 expected=1",
                             src);
                    drive(src, 1'b0, SYM_C, 1'b0);
                    return;
                end
            end
            @(negedge clock);
        end
        drive(src, 1'b0, SYM_C, 1'b0);
    endtask

    initial begin
        logic [1:0] q0[$];
        logic [1:0] q1[$];
        reset = 1'b1;
        req0 = 0; req1 = 0; sym0 = SYM_C; sym1 = SYM_C;
        last0 = 0; last1 = 0;
        repeat (3) @(negedge clock);
        chk("rst_gnt0", int'(gnt0), 0);
        chk("rst_gnt1", int'(gnt1), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_done_src", int'(done_src), 0);
        chk("rst_done_hits", int'(done_hits), 0);
        chk("rst_done_err", int'(done_err), 0);
        reset = 1'b0;
        @(negedge clock);

        // both request from reset: source 0 first
        q0 = '{SYM_A, SYM_B, SYM_C};
        q1 = '{SYM_A, SYM_B, SYM_C};
        expq.push_back('{1'b0, 4'd0, 1'b0});
        expq.push_back('{1'b1, 4'd0, 1'b0});
        fork
            send(1'b0, q0, 0, 1'b1);
            send(1'b1, q1, 0, 1'b1);
        join
        repeat (4) @(negedge clock);

        // source 0 alone, A,B,B
        gcnt0 = 0;
        q0 = '{SYM_A, SYM_B, SYM_B};
        expq.push_back('{1'b0, 4'd1, 1'b0});
        send(1'b0, q0, 0, 1'b1);
        repeat (4) @(negedge clock);
        chk("gnt0_cycles", gcnt0, 3);
        chk("hold_done", int'(done), 0);
        chk("hold_hits", int'(done_hits), 1);

        // rr now points to source 1; single-symbol burst on source 0
        q0 = '{SYM_B};
        q1 = '{SYM_A, SYM_B, SYM_B};
        expq.push_back('{1'b1, 4'd1, 1'b0});
        expq.push_back('{1'b0, 4'd0, 1'b0});
        fork
            send(1'b0, q0, 0, 1'b1);
            send(1'b1, q1, 0, 1'b1);
        join
        repeat (4) @(negedge clock);

        // source 1 with request gaps, two matches
        gcnt1 = 0;
        q1 = '{SYM_A, SYM_B, SYM_B, SYM_B, SYM_A, SYM_B, SYM_B};
        expq.push_back('{1'b1, 4'd2, 1'b0});
        send(1'b1, q1, 2, 1'b1);
        repeat (4) @(negedge clock);
        chk("gnt1_cycles_gaps", gcnt1, 19);

        // invalid symbol mid-burst
        q0 = '{SYM_A, SYM_INV, SYM_B, SYM_B};
        expq.push_back('{1'b0, 4'd0, 1'b1});
        send(1'b0, q0, 0, 1'b1);
        repeat (4) @(negedge clock);

        // saturation: 20 matches into a 4-bit counter
        q1 = {};
        for (int i = 0; i < 20; i++) begin
            q1.push_back(SYM_A);
            q1.push_back(SYM_B);
            q1.push_back(SYM_B);
        end
        expq.push_back('{1'b1, 4'd15, 1'b0});
        send(1'b1, q1, 0, 1'b1);
        repeat (4) @(negedge clock);

        // leave rr pointing at source 1
        q0 = '{SYM_C};
        expq.push_back('{1'b0, 4'd0, 1'b0});
        send(1'b0, q0, 0, 1'b1);
        repeat (4) @(negedge clock);

        // reset after two symbols of a burst
        q0 = '{SYM_A, SYM_B};
        send(1'b0, q0, 0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_rst_gnt0", int'(gnt0), 0);
        chk("mid_rst_gnt1", int'(gnt1), 0);
        chk("mid_rst_done", int'(done), 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // rr back at 0: source 0 first, fresh counters
        q0 = '{SYM_A, SYM_B, SYM_B};
        q1 = '{SYM_C, SYM_C};
        expq.push_back('{1'b0, 4'd1, 1'b0});
        expq.push_back('{1'b1, 4'd0, 1'b0});
        fork
            send(1'b0, q0, 0, 1'b1);
            send(1'b1, q1, 0, 1'b1);
        join
        repeat (10) @(negedge clock);

        chk("queue_empty", expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/abb_sched.md
ABB_SCHED -- requirements
Module: abb_sched

Interface
REQ-001 SHALL have parameter: HIT_W, 4, width of per-burst match counter.
REQ-002 SHALL have port: clock  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req0, req1  input  1 each  source 0/1 has a symbol valid.
REQ-005 SHALL have port: sym0, sym1  input  2 each  source 0/1 symbol (A=00, B=01, C=11, 10=invalid).
REQ-006 SHALL have port: last0, last1  input  1 each  symbol is final of its burst.
REQ-007 SHALL have port: gnt0, gnt1  output  1 each  registered grant; symbol consumed when reqN and gntN both high.
REQ-008 SHALL have port: done  output  1  one-cycle burst-complete pulse.
REQ-009 SHALL have port: done_src  output  1  source of completed burst.
REQ-010 SHALL have port: done_hits  output  HIT_W  A-B-B matches in completed burst.
REQ-011 SHALL have port: done_err  output  1  burst contained an invalid symbol.

Function
REQ-012 SHALL implement FSM IDLE -> RUN -> DRAIN -> IDLE.
REQ-013 In IDLE, if reqN is high, SHALL grant a source: only requester wins; if both, winner is the round-robin pointer rr (0 after reset); also pulses detector clear, clears hit count and err flag, enters RUN.
REQ-014 In RUN, gnt of the owner SHALL be 1, the other 0; other source never granted mid-burst.
REQ-015 Each consumed symbol SHALL be presented to the detector in its consumption cycle with valid=1; no consumption when owner req low (wait indefinitely, no timeout).
REQ-016 Consuming a symbol with last=1 SHALL move to DRAIN; gnt drops in the DRAIN cycle.
REQ-017 DRAIN SHALL last exactly one cycle, then IDLE; rr set to the other source of the burst owner.
REQ-018 Detector match output SHALL be registered: high in the cycle after the valid cycle completing A,B,B; overlapping patterns count (A,B,B,B = 1 match; A,B,B,A,B,B = 2).
REQ-019 C resets the detector pattern progress; A restarts progress at "A seen".
REQ-020 Invalid symbol 10 SHALL reset detector progress and set the burst err flag.
REQ-021 Hit counter SHALL increment on each cycle with match=1 in RUN or DRAIN, saturating at 2^HIT_W-1.
REQ-022 done SHALL pulse in the cycle after DRAIN with done_src/done_hits/done_err valid that cycle; fields hold value until next done.
REQ-023 Arbitration in that same IDLE cycle SHALL proceed normally (done and new grant start coincide; back-to-back bursts have 2 idle-grant cycles: DRAIN, IDLE).
REQ-024 Single-symbol burst (last on first symbol) SHALL be legal: RUN 1 cycle, DRAIN, done with hits 0.

Reset
REQ-025 On reset: state IDLE, gnt0=gnt1=0, rr=0, done=0, done_src=0, done_hits=0, done_err=0, detector progress and match cleared.
REQ-026 Reset mid-burst SHALL abandon the burst with no done pulse; first request after reset arbitrated from rr=0.

Structure
REQ-027 Package abb_pkg SHALL hold symbol encodings SYM_A, SYM_B, SYM_C, SYM_INV and FSM state encodings.
REQ-028 Sub-module abb_det SHALL hold the A-B-B detector (inputs clock, reset, clear, valid, sym; output match); the scheduler holds FSM, rr, grants, counters.

Verification
REQ-029 Source 0 alone sends A,B,B(last) -> gnt0 high 3 cycles, done pulse with done_src=0, done_hits=1, done_err=0.
REQ-030 Both req high from reset, each sending A,B,C(last) -> source 0 served first, then source 1; both done_hits=0; rr alternates.
REQ-031 Source 1 sends A,B,B,B,A,B,B(last) with req gaps of 2 cycles -> grant held throughout, done_hits=2.
REQ-032 Burst A,10,B,B(last) -> done_err=1, done_hits=0; 20x A,B,B with HIT_W=4 -> done_hits=15.
REQ-033 Reset asserted after 2 symbols of a burst -> no done, gnt0=gnt1=0 next cycle, next burst starts with cleared counters.
